hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Hazard detection and forwarding control for the 5-stage pipelined MIPS core.
- Sits directly upstream of the execute-stage operand 3-input muxes and drives their 2-bit selects.
- Also drives the 1-bit decode-stage branch-compare forwarding selects, the fetch/decode stall enables and the execute flush.
- Tracks multi-cycle mult/div occupancy, so HI/LO consumers stall until the result is ready.

Parameters:
- MD_LATENCY, 32, number of cycles the mult/div unit stays busy after a start (must be >= 1).
- CNT_W, $clog2(MD_LATENCY+1), busy counter width (derived; not overridden).

Ports:
- clk  in  1  core clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- rsD, rtD  in  5 each  source registers of the instruction in decode.
- rsE, rtE  in  5 each  source registers in execute (rtE is also the load destination).
- writeregE, writeregM, writeregW  in  5 each  destination register per stage.
- regwriteE, regwriteM, regwriteW  in  1 each  register-write enables per stage.
- memtoregE, memtoregM  in  1 each  instruction is a load.
- branchD  in  1  decode holds a branch that compares in decode.
- mduseD  in  1  decode holds mult/div/mfhi/mflo.
- mdstartE  in  1  execute holds mult/div (starts the unit this cycle).
- forwardAE, forwardBE  out  2 each  execute operand selects: 00 regfile, 01 writeback result, 10 memory-stage ALU result.
- forwardAD, forwardBD  out  1 each  decode compare select: 1 = memory-stage ALU result.
- stallF, stallD  out  1 each  hold the PC and the IF/ID register.
- flushE  out  1  clear the ID/EX register (insert bubble).
- mdbusy  out  1  mult/div unit occupied.

Behaviour:
- Register 0 never matches. Every comparison below also requires the compared source to be non-zero.
- forwardAE:
  - 10 if regwriteM and rsE==writeregM.
  - else 01 if regwriteW and rsE==writeregW.
  - else 00.
  - The memory stage wins when both match.
- forwardBE: same rule as forwardAE, using rtE.
- forwardAD = regwriteM and rsD==writeregM. forwardBD: same, using rtD.
- lwstall = memtoregE and (rtE==rsD or rtE==rtD).
- branchstall = branchD and either:
  - regwriteE and writeregE matches rsD or rtD, or
  - memtoregM and writeregM matches rsD or rtD.
- mdstall = mduseD and mdbusy.
- stallF = stallD = flushE = lwstall | branchstall | mdstall.
- All forwarding and stall outputs are combinational, with no added latency.
- Busy counter (the only state), updated on the rising edge of clk:
  - if mdstartE and cnt==0: cnt <= MD_LATENCY.
  - else if cnt!=0: cnt <= cnt-1.
  - mdbusy = (cnt!=0).
- Timing: mult in E at cycle t → mdbusy high for cycles t+1 .. t+MD_LATENCY, low at t+MD_LATENCY+1. A HI/LO reader in D is released in that cycle.
- mdstartE while cnt!=0 is ignored and the counter is not reloaded. This is illegal by construction, because the second mult/div is stalled in D; the bench asserts it never occurs.
- flushE does not affect the counter. The instruction in E at the flush is valid and its start still counts.
- Reset asserted, including mid-count: cnt clears immediately (async) and mdbusy drops the same instant.
- Output values during and after reset, all other inputs zero: forwardAE/BE = 00, forwardAD/BD = 0, stallF/stallD/flushE = 0, mdbusy = 0.
- Simultaneous lwstall and mdstall: one stall and one flush per cycle, with no double-counting.

Decomposition:
- Shared package cpu_pkg holds:
  - forwarding select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - REG_ADDR_W=5.
- One natural sub-module: md_busy_counter. It takes clk, reset, start and produces busy, parameterised by MD_LATENCY.
- Forwarding and stall logic stay combinational in hazard_unit.

Test Plan:
- Forwarding priority: rsE=5, writeregM=5/regwriteM=1, writeregW=5/regwriteW=1 → forwardAE=10. Drop regwriteM → 01. rsE=0 with all matches → 00.
- Load-use: memtoregE=1, rtE=8, rsD=8 → stallF=stallD=flushE=1. Next cycle memtoregE=0, regwriteM=1, writeregM=8 (load now in M) → stalls 0, forwardAE=00 (the bench also checks the 01 writeback path in the following cycle).
- Branch: branchD=1, rsD=3, regwriteE=1, writeregE=3 → stall=1. Then writeregM=3, regwriteM=1, memtoregM=0 → stall=0, forwardAD=1.
- Mult/div occupancy, MD_LATENCY=4: mdstartE pulse at cycle 0 → mdbusy high cycles 1-4. mduseD=1 from cycle 1 → stallD high cycles 1-4, low at cycle 5.
- Reset mid-operation: assert reset at cycle 2 of a busy window, async to the clock edge → mdbusy=0 and stallD=0 immediately. After release, mduseD passes with no stall.
- Illegal re-start: mdstartE held high for 3 cycles → counter loads once; mdbusy width is exactly MD_LATENCY.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS core: register address width,
// forwarding mux select encodings and a register-match helper.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Execute-stage operand mux select encodings
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // True when a source register depends on a destination register.
    // $zero is hard-wired, so it never creates a dependency.
    function automatic logic regMatch(input reg_addr_t src, input reg_addr_t dst);
        return (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy tracker. A start loads the latency into a down-counter,
// and the unit reports busy until the counter drains back to zero. A start
// that arrives while the unit is already busy is ignored.
module md_busy_counter #(
    parameter int MD_LATENCY = 32
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_start,
    output logic o_busy
);

    localparam int CNT_W = $clog2(MD_LATENCY + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_idle;

    assign w_idle = (r_cnt == '0);

    // Load on an idle start, otherwise count down to zero; reset clears at once
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_start && w_idle) begin
            r_cnt <= CNT_W'(MD_LATENCY);
        end else if (!w_idle) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_busy = !w_idle;

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage MIPS pipeline.
// Forwarding selects and stall/flush controls are purely combinational; the
// only state is the mult/div busy counter held in md_busy_counter.
module hazard_unit
    import cpu_pkg::*;
#(
    parameter int MD_LATENCY = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [REG_ADDR_W-1:0] i_rsD,
    input  logic [REG_ADDR_W-1:0] i_rtD,
    input  logic [REG_ADDR_W-1:0] i_rsE,
    input  logic [REG_ADDR_W-1:0] i_rtE,
    input  logic [REG_ADDR_W-1:0] i_writeregE,
    input  logic [REG_ADDR_W-1:0] i_writeregM,
    input  logic [REG_ADDR_W-1:0] i_writeregW,
    input  logic                  i_regwriteE,
    input  logic                  i_regwriteM,
    input  logic                  i_regwriteW,
    input  logic                  i_memtoregE,
    input  logic                  i_memtoregM,
    input  logic                  i_branchD,
    input  logic                  i_mduseD,
    input  logic                  i_mdstartE,
    output logic [1:0]            o_forwardAE,
    output logic [1:0]            o_forwardBE,
    output logic                  o_forwardAD,
    output logic                  o_forwardBD,
    output logic                  o_stallF,
    output logic                  o_stallD,
    output logic                  o_flushE,
    output logic                  o_mdbusy
);

    logic [1:0] w_forwardAE;
    logic [1:0] w_forwardBE;
    logic       w_forwardAD;
    logic       w_forwardBD;
    logic       w_lwstall;
    logic       w_branchstall;
    logic       w_mdstall;
    logic       w_stall;
    logic       w_mdbusy;

    // Mult/div occupancy; a flush does not cancel the start in execute
    md_busy_counter #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_busy_counter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (i_mdstartE),
        .o_busy  (w_mdbusy)
    );

    // Execute operand forwarding; the memory stage is younger and wins over writeback
    always_comb begin
        w_forwardAE = FWD_RF;
        if (i_regwriteM && regMatch(i_rsE, i_writeregM)) begin
            w_forwardAE = FWD_MEM;
        end else if (i_regwriteW && regMatch(i_rsE, i_writeregW)) begin
            w_forwardAE = FWD_WB;
        end

        w_forwardBE = FWD_RF;
        if (i_regwriteM && regMatch(i_rtE, i_writeregM)) begin
            w_forwardBE = FWD_MEM;
        end else if (i_regwriteW && regMatch(i_rtE, i_writeregW)) begin
            w_forwardBE = FWD_WB;
        end
    end

    // Decode branch-compare forwarding from the memory-stage ALU result
    always_comb begin
        w_forwardAD = i_regwriteM && regMatch(i_rsD, i_writeregM);
        w_forwardBD = i_regwriteM && regMatch(i_rtD, i_writeregM);
    end

    // Stall sources: load-use, branch operand not yet available, HI/LO still being produced
    always_comb begin
        w_lwstall = i_memtoregE &&
                    (regMatch(i_rsD, i_rtE) || regMatch(i_rtD, i_rtE));

        w_branchstall = i_branchD &&
                        ((i_regwriteE &&
                          (regMatch(i_rsD, i_writeregE) || regMatch(i_rtD, i_writeregE))) ||
                         (i_memtoregM &&
                          (regMatch(i_rsD, i_writeregM) || regMatch(i_rtD, i_writeregM))));

        w_mdstall = i_mduseD && w_mdbusy;

        w_stall = w_lwstall || w_branchstall || w_mdstall;
    end

    assign o_forwardAE = w_forwardAE;
    assign o_forwardBE = w_forwardBE;
    assign o_forwardAD = w_forwardAD;
    assign o_forwardBD = w_forwardBD;
    assign o_stallF    = w_stall;
    assign o_stallD    = w_stall;
    assign o_flushE    = w_stall;
    assign o_mdbusy    = w_mdbusy;

endmodule
